// File: rtl/mult_8x8_seq.sv
// Sequential 8x8 unsigned multiplier that time-shares a single 4x4 multiplier
// over four steps, producing one 16-bit product every five cycles at most.

module mult_4x4 (
    input  logic [3:0] x,
    input  logic [3:0] z,
    output logic [7:0] p
);

    // Combinational shift-and-add over the four multiplier bits.
    always_comb begin
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (z[i]) begin
                p = p + ({4'h0, x} << i);
            end
        end
    end

endmodule

module mult_8x8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] y
);

    typedef enum logic [2:0] {
        IDLE,
        STEP0,
        STEP1,
        STEP2,
        STEP3
    } state_t;

    state_t      state;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;
    logic [15:0] acc_next;

    // Each step picks one nibble pair of the captured operands.
    always_comb begin
        nib_a = a_reg[3:0];
        nib_b = b_reg[3:0];
        case (state)
            STEP1: begin
                nib_a = a_reg[7:4];
            end
            STEP2: begin
                nib_b = b_reg[7:4];
            end
            STEP3: begin
                nib_a = a_reg[7:4];
                nib_b = b_reg[7:4];
            end
            default: begin
                nib_a = a_reg[3:0];
                nib_b = b_reg[3:0];
            end
        endcase
    end

    mult_4x4 u_mult_4x4 (
        .x (nib_a),
        .z (nib_b),
        .p (pp)
    );

    // Place the partial product at its weight: 0, 4, 4 and 8 bits.
    always_comb begin
        pp_shifted = {8'h00, pp};
        case (state)
            STEP1, STEP2: pp_shifted = {4'h0, pp, 4'h0};
            STEP3:        pp_shifted = {pp, 8'h00};
            default:      pp_shifted = {8'h00, pp};
        endcase
    end

    assign acc_next = acc + pp_shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= 8'h00;
            b_reg <= 8'h00;
            acc   <= 16'h0000;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= 16'h0000;
                        busy  <= 1'b1;
                        state <= STEP0;
                    end
                end
                STEP0: begin
                    acc   <= acc_next;
                    state <= STEP1;
                end
                STEP1: begin
                    acc   <= acc_next;
                    state <= STEP2;
                end
                STEP2: begin
                    acc   <= acc_next;
                    state <= STEP3;
                end
                STEP3: begin
                    // Final term goes straight into y; busy drops as done rises.
                    acc   <= acc_next;
                    y     <= acc_next;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_8x8_seq.sv
// Self-checking bench for mult_8x8_seq: a transaction-level model checked every
// cycle, plus directed scenarios with literal expected products and timing.

module tb_mult_8x8_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] y;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_y;
    logic [15:0] m_prod;
    logic        m_busy;
    logic        m_done;
    int          m_rem;

    mult_8x8_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted request yields a*b four edges later; requests while busy are dropped.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_y    <= 16'h0000;
            m_prod <= 16'h0000;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_prod <= {8'h00, a} * {8'h00, b};
                    m_rem  <= 4;
                    m_busy <= 1'b1;
                end
            end else if (m_rem == 1) begin
                m_y    <= m_prod;
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_rem  <= 0;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check_output("model_busy", 32'(busy), 32'(m_busy));
            check_output("model_done", 32'(done), 32'(m_done));
            check_output("model_y", 32'(y), 32'(m_y));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait, bounded, for done; counts cycles and busy samples seen before it.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 10) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        check_output("done_seen", 32'(done), 32'd1);
    endtask

    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv,
                                  input logic [15:0] exp_y, input string tag);
        int cycles;
        int busy_cnt;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom_range(0, 255));
        b     = 8'($urandom_range(0, 255));
        wait_done(cycles, busy_cnt);
        check_output({tag, "_y"}, 32'(y), 32'(exp_y));
        check_output({tag, "_latency"}, 32'(cycles), 32'd4);
        check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        @(negedge clk);
        check_output({tag, "_done_clear"}, 32'(done), 32'd0);
    endtask

    function automatic logic [3:0] pick_nibble(input int sel);
        logic [3:0] bnd [4];
        bnd[0] = 4'h0;
        bnd[1] = 4'h1;
        bnd[2] = 4'hE;
        bnd[3] = 4'hF;
        return bnd[sel];
    endfunction

    initial begin
        int cycles;
        int busy_cnt;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] ref_y;

        rst   = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_y", 32'(y), 32'h0000);

        // Start is already high on the first edge after reset falls.
        rst = 1'b0;
        apply_stimulus(8'h12, 8'h34, 16'h03A8, "basic");
        apply_stimulus(8'hFF, 8'hFF, 16'hFE01, "max");
        apply_stimulus(8'h00, 8'hFF, 16'h0000, "zero");

        // Start held high through STEP1-STEP3 must not disturb the product.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(negedge clk);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_output("held_done", 32'(done), 32'd1);
        check_output("held_y", 32'(y), 32'h03A8);
        @(negedge clk);
        start = 1'b0;
        check_output("held_accept_busy", 32'(busy), 32'd1);
        check_output("held_accept_done", 32'(done), 32'd0);
        wait_done(cycles, busy_cnt);
        check_output("held_second_y", 32'(y), 32'hFE01);
        check_output("held_second_gap", 32'(cycles), 32'd4);

        // Back-to-back: new request issued in the done cycle.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles, busy_cnt);
        check_output("b2b_first_y", 32'(y), 32'h03A8);
        start = 1'b1;
        a     = 8'h0F;
        b     = 8'h10;
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_done_fall", 32'(done), 32'd0);
        check_output("b2b_busy", 32'(busy), 32'd1);
        wait_done(cycles, busy_cnt);
        check_output("b2b_y", 32'(y), 32'h00F0);
        check_output("b2b_gap", 32'(cycles), 32'd4);

        // Reset in STEP2 aborts the multiply with no done pulse.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_y", 32'(y), 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("abort_no_done", 32'(done), 32'd0);
        end
        apply_stimulus(8'h03, 8'h05, 16'h000F, "post_reset");

        // Every combination of boundary nibbles 0x0, 0x1, 0xE, 0xF.
        for (int i = 0; i < 256; i++) begin
            ra    = {pick_nibble((i >> 6) & 3), pick_nibble((i >> 4) & 3)};
            rb    = {pick_nibble((i >> 2) & 3), pick_nibble(i & 3)};
            ref_y = {8'h00, ra} * {8'h00, rb};
            apply_stimulus(ra, rb, ref_y, "nibble");
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ra[3:0] = pick_nibble(int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) rb[7:4] = pick_nibble(int'($urandom_range(0, 3)));
            ref_y = {8'h00, ra} * {8'h00, rb};
            apply_stimulus(ra, rb, ref_y, "random");
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
